// File: rtl/zxunouart_fifo.sv
// zxunouart_fifo: ZX-Uno register-mapped UART with TX/RX FIFOs, loopback and RTS flow control.
module zxunouart_fifo #(
    parameter logic [7:0]  UARTDATA  = 8'hC6,
    parameter logic [7:0]  UARTSTAT  = 8'hC7,
    parameter logic [7:0]  UARTCTRL  = 8'hC8,
    parameter logic [7:0]  UARTDIVL  = 8'hC9,
    parameter logic [7:0]  UARTDIVH  = 8'hCA,
    parameter int unsigned FIFO_AW   = 4,
    parameter logic [15:0] DIV_RESET = 16'd243
) (
    input  logic       clk_bus,
    input  logic       rst_n,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       uart_rts
);
    localparam int unsigned   DEPTH    = 1 << FIFO_AW;
    localparam int unsigned   CW       = FIFO_AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [15:0]   MIN_PER  = 16'd16;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [CW-1:0]      cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

    // ---------------- register bus ----------------
    logic       bus_en;
    logic       sel_data, sel_stat, sel_ctrl, sel_divl, sel_divh;
    logic [3:0] wr_hit, wr_prev, wr_go;   // {divh, divl, ctrl, data}
    logic [1:0] rd_hit, rd_prev, rd_done; // {stat, data}
    logic       loopback;
    logic [15:0] divisor, eff_per;
    logic       tx_flush, rx_flush, stat_clr;

    assign sel_data = (zxuno_addr == UARTDATA);
    assign sel_stat = (zxuno_addr == UARTSTAT);
    assign sel_ctrl = (zxuno_addr == UARTCTRL);
    assign sel_divl = (zxuno_addr == UARTDIVL);
    assign sel_divh = (zxuno_addr == UARTDIVH);

    assign wr_hit  = {sel_divh, sel_divl, sel_ctrl, sel_data} & {4{zxuno_regwr & bus_en}};
    assign rd_hit  = {sel_stat, sel_data} & {2{zxuno_regrd & bus_en}};
    assign wr_go   = wr_hit & ~wr_prev;
    assign rd_done = rd_prev & ~rd_hit;

    assign tx_flush = wr_go[1] & din[1];
    assign rx_flush = wr_go[1] & din[0];
    assign stat_clr = rd_done[1];
    assign eff_per  = (divisor < MIN_PER) ? MIN_PER : divisor;

    // Strobe edge tracking; bus accesses are held off for the first edge after reset release
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            bus_en  <= 1'b0;
            wr_prev <= '0;
            rd_prev <= '0;
        end else begin
            bus_en  <= 1'b1;
            wr_prev <= wr_hit;
            rd_prev <= rd_hit;
        end
    end

    // Control and divisor registers
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            loopback <= 1'b0;
            divisor  <= DIV_RESET;
        end else begin
            if (wr_go[1]) loopback      <= din[7];
            if (wr_go[2]) divisor[7:0]  <= din;
            if (wr_go[3]) divisor[15:8] <= din;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0] tx_mem [DEPTH];
    ptr_t       tx_wp, tx_rp;
    cnt_t       tx_cnt;
    logic       tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_go[0] & ~tx_full;

    // TX storage
    always_ff @(posedge clk_bus) begin
        if (tx_push) tx_mem[tx_wp] <= din;
    end

    // TX pointers and occupancy; a flush drops pending bytes only
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + ptr_t'(1);
            if (tx_flush) begin
                tx_rp  <= tx_wp;
                tx_cnt <= '0;
            end else begin
                if (tx_pop) tx_rp <= tx_rp + ptr_t'(1);
                if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + cnt_t'(1);
                else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - cnt_t'(1);
            end
        end
    end

    // ---------------- TX state machine ----------------
    uart_st_t    tx_st, tx_st_n;
    logic [15:0] tx_tmr, tx_tmr_n, tx_per, tx_per_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic        tx_line, tx_line_n, tx_last, tx_avail;

    assign tx_last  = (tx_tmr == tx_per - 16'd1);
    assign tx_avail = ~tx_empty & ~tx_flush;

    // TX state register
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_st   <= S_IDLE;
            tx_tmr  <= '0;
            tx_per  <= MIN_PER;
            tx_bit  <= '0;
            tx_sh   <= '0;
            tx_line <= 1'b1;
        end else begin
            tx_st   <= tx_st_n;
            tx_tmr  <= tx_tmr_n;
            tx_per  <= tx_per_n;
            tx_bit  <= tx_bit_n;
            tx_sh   <= tx_sh_n;
            tx_line <= tx_line_n;
        end
    end

    // TX next state: line level is registered together with the state it belongs to
    always_comb begin
        tx_st_n   = tx_st;
        tx_tmr_n  = tx_tmr + 16'd1;
        tx_per_n  = tx_per;
        tx_bit_n  = tx_bit;
        tx_sh_n   = tx_sh;
        tx_line_n = tx_line;
        tx_pop    = 1'b0;
        unique case (tx_st)
            S_IDLE: begin
                tx_tmr_n  = '0;
                tx_line_n = 1'b1;
                if (tx_avail) begin
                    tx_pop    = 1'b1;
                    tx_sh_n   = tx_mem[tx_rp];
                    tx_per_n  = eff_per;
                    tx_st_n   = S_START;
                    tx_line_n = 1'b0;
                end
            end
            S_START: begin
                if (tx_last) begin
                    tx_tmr_n  = '0;
                    tx_bit_n  = '0;
                    tx_st_n   = S_DATA;
                    tx_line_n = tx_sh[0];
                end
            end
            S_DATA: begin
                if (tx_last) begin
                    tx_tmr_n = '0;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_st_n   = S_STOP;
                        tx_line_n = 1'b1;
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_line_n = tx_sh[1];
                    end
                end
            end
            S_STOP: begin
                if (tx_last) begin
                    tx_tmr_n = '0;
                    if (tx_avail) begin
                        tx_pop    = 1'b1;
                        tx_sh_n   = tx_mem[tx_rp];
                        tx_per_n  = eff_per;
                        tx_st_n   = S_START;
                        tx_line_n = 1'b0;
                    end else begin
                        tx_st_n   = S_IDLE;
                        tx_line_n = 1'b1;
                    end
                end
            end
        endcase
    end

    assign uart_tx = loopback ? 1'b1 : tx_line;

    // ---------------- RX input conditioning ----------------
    logic [1:0] rx_sync;
    logic       rx_in, rx_prev;

    assign rx_in = rx_sync[1];

    // Two-flop synchronizer with loopback source select, plus edge history
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], loopback ? tx_line : uart_rx};
            rx_prev <= rx_in;
        end
    end

    // ---------------- RX state machine ----------------
    uart_st_t    rx_st, rx_st_n;
    logic [15:0] rx_tmr, rx_tmr_n, rx_per, rx_per_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic        rx_push_req, rx_ferr_set, rx_last, rx_half;

    assign rx_last = (rx_tmr == rx_per - 16'd1);
    assign rx_half = (rx_tmr == (rx_per >> 1) - 16'd1);

    // RX state register
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_st  <= S_IDLE;
            rx_tmr <= '0;
            rx_per <= MIN_PER;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            rx_st  <= rx_st_n;
            rx_tmr <= rx_tmr_n;
            rx_per <= rx_per_n;
            rx_bit <= rx_bit_n;
            rx_sh  <= rx_sh_n;
        end
    end

    // RX next state: half-period to mid start bit, then full periods per sample
    always_comb begin
        rx_st_n     = rx_st;
        rx_tmr_n    = rx_tmr + 16'd1;
        rx_per_n    = rx_per;
        rx_bit_n    = rx_bit;
        rx_sh_n     = rx_sh;
        rx_push_req = 1'b0;
        rx_ferr_set = 1'b0;
        unique case (rx_st)
            S_IDLE: begin
                rx_tmr_n = '0;
                if (rx_prev && !rx_in) begin
                    rx_per_n = eff_per;
                    rx_st_n  = S_START;
                end
            end
            S_START: begin
                if (rx_half) begin
                    rx_tmr_n = '0;
                    rx_bit_n = '0;
                    rx_st_n  = rx_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_last) begin
                    rx_tmr_n = '0;
                    rx_sh_n  = {rx_in, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_st_n  = S_STOP;
                    else                rx_bit_n = rx_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (rx_last) begin
                    rx_tmr_n    = '0;
                    rx_st_n     = S_IDLE;
                    rx_push_req = rx_in;
                    rx_ferr_set = ~rx_in;
                end
            end
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0] rx_mem [DEPTH];
    ptr_t       rx_wp, rx_rp;
    cnt_t       rx_cnt;
    logic       rx_empty, rx_pop, rx_block, rx_wr, rx_ovf_set;
    logic       rx_ovf, rx_ferr;

    assign rx_empty   = (rx_cnt == '0);
    assign rx_pop     = rd_done[0] & ~rx_empty;
    assign rx_block   = (rx_cnt == FULL_CNT) & ~rx_pop & ~rx_flush;
    assign rx_wr      = rx_push_req & ~rx_block;
    assign rx_ovf_set = rx_push_req & rx_block;

    // RX storage
    always_ff @(posedge clk_bus) begin
        if (rx_wr) rx_mem[rx_wp] <= rx_sh;
    end

    // RX pointers and occupancy; a flush keeps a byte arriving in the same cycle
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_wr) rx_wp <= rx_wp + ptr_t'(1);
            if (rx_flush) begin
                rx_rp  <= rx_wp;
                rx_cnt <= rx_wr ? cnt_t'(1) : cnt_t'(0);
            end else begin
                if (rx_pop) rx_rp <= rx_rp + ptr_t'(1);
                if (rx_wr && !rx_pop)      rx_cnt <= rx_cnt + cnt_t'(1);
                else if (!rx_wr && rx_pop) rx_cnt <= rx_cnt - cnt_t'(1);
            end
        end
    end

    // Sticky error flags and RTS; a new error beats a status-read clear
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf   <= 1'b0;
            rx_ferr  <= 1'b0;
            uart_rts <= 1'b0;
        end else begin
            rx_ovf   <= rx_ovf_set  | (rx_ovf  & ~stat_clr);
            rx_ferr  <= rx_ferr_set | (rx_ferr & ~stat_clr);
            uart_rts <= ((FULL_CNT - rx_cnt) <= cnt_t'(2));
        end
    end

    // ---------------- read mux ----------------
    logic [7:0] rd_val;
    logic       rd_sel;

    // Combinational register readback
    always_comb begin
        rd_val = 8'h00;
        rd_sel = 1'b0;
        if (zxuno_regrd) begin
            rd_sel = 1'b1;
            if (sel_data)      rd_val = rx_empty ? 8'h00 : rx_mem[rx_rp];
            else if (sel_stat) rd_val = {~rx_empty, tx_full, rx_ovf,
                                         tx_empty & (tx_st == S_IDLE), rx_ferr, 3'b000};
            else if (sel_ctrl) rd_val = {loopback, 7'b0};
            else if (sel_divl) rd_val = divisor[7:0];
            else if (sel_divh) rd_val = divisor[15:8];
            else               rd_sel = 1'b0;
        end
    end

    assign oe_n = ~rd_sel;
    assign dout = rd_sel ? rd_val : 8'hzz;

endmodule

// File: tb/tb_zxunouart_fifo.sv
// tb_zxunouart_fifo: scoreboard bench for the register-mapped UART with FIFOs.
module tb_zxunouart_fifo;
    localparam logic [7:0] A_DATA = 8'hC6;
    localparam logic [7:0] A_STAT = 8'hC7;
    localparam logic [7:0] A_CTRL = 8'hC8;
    localparam logic [7:0] A_DIVL = 8'hC9;
    localparam logic [7:0] A_DIVH = 8'hCA;

    logic       clk_bus = 1'b0;
    logic       rst_n;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;
    logic       uart_tx;
    logic       uart_rx;
    logic       uart_rts;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    logic       tx_mon_en = 1'b1;
    rd_exp_t    rd_e;

    zxunouart_fifo dut (
        .clk_bus     (clk_bus),
        .rst_n       (rst_n),
        .zxuno_addr  (zxuno_addr),
        .zxuno_regrd (zxuno_regrd),
        .zxuno_regwr (zxuno_regwr),
        .din         (din),
        .dout        (dout),
        .oe_n        (oe_n),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .uart_rts    (uart_rts)
    );

    always #5 clk_bus = ~clk_bus;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Read monitor: every cycle the block drives the bus is matched to the next expected read
    initial begin
        forever begin
            @(negedge clk_bus);
            if (oe_n === 1'b0) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected got=%h", dout);
                end else begin
                    rd_e = rd_q.pop_front();
                    if (dout !== rd_e.val) begin
                        bad++;
                        $display("FAIL %s got=%h exp=%h", rd_e.name, dout, rd_e.val);
                    end
                end
            end
        end
    end

    // TX line monitor: a start bit opens a 160-cycle window checked against the expected frame
    initial begin
        logic [9:0] frame;
        logic [7:0] b;
        int         bad_k;
        logic       bad_v;
        forever begin
            @(negedge clk_bus);
            if (tx_mon_en && rst_n === 1'b1 && uart_tx === 1'b0) begin
                total++;
                if (tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected_frame at %0t", $time);
                    repeat (159) @(negedge clk_bus);
                end else begin
                    b     = tx_q.pop_front();
                    frame = {1'b1, b, 1'b0};
                    bad_k = -1;
                    bad_v = 1'b0;
                    for (int k = 0; k < 160; k++) begin
                        if (k > 0) @(negedge clk_bus);
                        if (bad_k < 0 && uart_tx !== frame[k/16]) begin
                            bad_k = k;
                            bad_v = uart_tx;
                        end
                    end
                    if (bad_k >= 0) begin
                        bad++;
                        $display("FAIL tx_frame byte=%h cycle=%0d got=%b exp=%b",
                                 b, bad_k, bad_v, frame[bad_k/16]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_bus);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold);
        zxuno_addr  = a;
        din         = d;
        zxuno_regwr = 1'b1;
        tick(hold);
        zxuno_regwr = 1'b0;
        tick(1);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        zxuno_addr  = a;
        zxuno_regrd = 1'b1;
        tick(1);
        zxuno_regrd = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            tick(16);
        end
        uart_rx = 1'b1;
        tick(4);
    endtask

    initial begin
        rst_n       = 1'b0;
        zxuno_addr  = 8'h00;
        zxuno_regrd = 1'b0;
        zxuno_regwr = 1'b0;
        din         = 8'h00;
        uart_rx     = 1'b1;
        tick(3);
        chk("rst_tx", 8'(uart_tx), 8'h01);
        chk("rst_rts", 8'(uart_rts), 8'h00);
        rst_n = 1'b1;
        tick(3);
        chk("idle_oe_n", 8'(oe_n), 8'h01);
        rd(A_STAT, 8'h10, "rst_stat");
        rd(A_DIVL, 8'hF3, "rst_divl");
        rd(A_DIVH, 8'h00, "rst_divh");
        rd(A_CTRL, 8'h00, "rst_ctrl");
        rd(A_DATA, 8'h00, "rst_data_empty");

        // divisor 16, held write sends exactly one frame
        wr(A_DIVL, 8'h10, 1);
        wr(A_DIVH, 8'h00, 1);
        rd(A_DIVL, 8'h10, "div_l");
        rd(A_DIVH, 8'h00, "div_h");
        tx_q.push_back(8'hA5);
        wr(A_DATA, 8'hA5, 5);
        rd(A_STAT, 8'h00, "stat_tx_busy");
        tick(200);
        rd(A_STAT, 8'h10, "stat_tx_idle");

        // overfill TX while a frame is in flight, then flush pending
        tx_q.push_back(8'h81);
        wr(A_DATA, 8'h81, 1);
        tick(2);
        for (int i = 0; i < 18; i++) wr(A_DATA, 8'(8'h10 + i), 1);
        rd(A_STAT, 8'h40, "stat_tx_full");
        wr(A_CTRL, 8'h02, 1);
        rd(A_STAT, 8'h00, "stat_after_txflush");
        tick(250);
        rd(A_STAT, 8'h10, "stat_txflush_done");

        // loopback
        wr(A_CTRL, 8'h80, 1);
        rd(A_CTRL, 8'h80, "ctrl_loopback");
        wr(A_DATA, 8'h3C, 1);
        wr(A_DATA, 8'hC3, 1);
        tick(40);
        chk("lb_tx_held", 8'(uart_tx), 8'h01);
        tick(360);
        rd(A_STAT, 8'h90, "lb_stat");
        rd(A_DATA, 8'h3C, "lb_data0");
        rd(A_DATA, 8'hC3, "lb_data1");
        rd(A_STAT, 8'h10, "lb_stat_empty");
        wr(A_CTRL, 8'h00, 1);

        // RX overflow and RTS threshold
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(8'h40 + i), 1'b1);
            if (i == 12) chk("rts_13_used", 8'(uart_rts), 8'h00);
            if (i == 13) chk("rts_14_used", 8'(uart_rts), 8'h01);
        end
        rd(A_STAT, 8'hB0, "stat_rx_ovf");
        for (int i = 0; i < 16; i++) rd(A_DATA, 8'(8'h40 + i), "rx_fifo_data");
        rd(A_STAT, 8'h10, "stat_ovf_cleared");
        chk("rts_drained", 8'(uart_rts), 8'h00);

        // framing error
        send_frame(8'h55, 1'b0);
        tick(16);
        rd(A_STAT, 8'h18, "stat_ferr");
        rd(A_STAT, 8'h10, "stat_ferr_cleared");

        // reset mid data bit
        tx_mon_en = 1'b0;
        wr(A_DATA, 8'h00, 1);
        tick(70);
        chk("tx_mid_data", 8'(uart_tx), 8'h00);
        rst_n = 1'b0;
        #1;
        chk("tx_in_reset", 8'(uart_tx), 8'h01);
        chk("rts_in_reset", 8'(uart_rts), 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        rd(A_STAT, 8'h10, "post_rst_stat");
        rd(A_DIVL, 8'hF3, "post_rst_divl");
        rd(A_DIVH, 8'h00, "post_rst_divh");
        tick(4);

        chk("rd_queue_drained", 8'(rd_q.size()), 8'h00);
        chk("tx_queue_drained", 8'(tx_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
